avg_channel_scheduler: RTL and testbench
========================================

# avg_channel_scheduler

Round-robin scheduler that shares one moving-average filter instance between `CHANNELS` sample producers. Per grant it streams exactly one window of samples from the granted channel into the filter's `fit_data`/`data_in` port, waits for the filter's `isFiltered` pulse, and returns the averaged value tagged with its channel number on a valid/ready output. It sits between the sensor/ingress channels and the downstream consumer of filtered data in the cryptoprocessor datapath.

## Interface

Parameters:
- `N`, 16, sample and result width; equals the filter's `N`.
- `CHANNELS`, 4, number of requesters; power of two, 2 to 16.
- `WINDOW`, 4, samples fed per grant; equals the filter's `WINDOW_SIZE`.
- `TIMEOUT`, 8, maximum WAIT cycles before the error abort; at least 3.

Ports (`CW` = clog2(`CHANNELS`)):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  `CHANNELS*N`  channel k sample at bits [k*N +: N].
- `in_valid`  in  `CHANNELS`  per-channel sample valid.
- `in_ready`  out  `CHANNELS`  per-channel accept; at most one bit high.
- `filt_data`  out  N  drives the filter's `data_in`.
- `filt_fit`  out  1  drives the filter's `fit_data`.
- `filt_done`  in  1  from the filter's `isFiltered`.
- `filt_result`  in  N  from the filter's `data_out`.
- `out_data`  out  N  averaged result.
- `out_chan`  out  CW  channel that produced `out_data`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accept.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky timeout flag.

## Operation

- FSM states: IDLE, FEED, WAIT, OUT. Registered state, grant index `g`, round-robin pointer `last`, sample count `cnt`, and wait count `wcnt`.
- IDLE: when any `in_valid` bit is high, grant the first valid channel searching from `last+1` (mod `CHANNELS`). Register `g`, clear `cnt`, and go to FEED. No sample is accepted in IDLE.
- FEED: `in_ready[g]`=1 and all other bits 0. `filt_fit` = `in_valid[g]`, `filt_data` = `in_data[g]`, both combinational. A sample is accepted in each cycle with `in_valid[g]`=1, which increments `cnt`. Gaps in `in_valid[g]` are allowed and the filter holds its sum. Valid bits on other channels are ignored. The accept that takes `cnt` to `WINDOW` moves the FSM to WAIT and clears `wcnt`.
- WAIT: `filt_fit`=0 and `in_ready`=0. On `filt_done`=1, register `out_data`=`filt_result` and `out_chan`=`g`, then go to OUT. Otherwise increment `wcnt`. When `wcnt` reaches `TIMEOUT-1` without `filt_done`, set `err`=1, set `last`=`g`, and return to IDLE.
- OUT: `out_valid`=1. `out_data` and `out_chan` stay stable until `out_ready`=1. On accept, set `last`=`g` and go to IDLE.
- `filt_done` outside WAIT is ignored.
- `filt_fit` is never high outside FEED. It is never high for more than `WINDOW` accepts per grant, because extra pulses would corrupt the filter's sum.
- Result arithmetic belongs to the filter: floor(sum/`WINDOW`), where the sum is N+2 bits wide. The scheduler passes the result through unmodified.
- `err` clears only on reset. The scheduler keeps running after `err` is set.

## Timing

- Reset values: state=IDLE, `last`=`CHANNELS-1` (so channel 0 wins first), `cnt`=0, `wcnt`=0, `out_valid`=0, `out_data`=0, `out_chan`=0, `err`=0, `busy`=0, `in_ready`=0, `filt_fit`=0, `filt_data`=0.
- The filter shares `rst`. Reset in any state aborts the window, and both blocks restart clean.
- Minimum latency with `in_valid[g]` held high:
  - cycle t0: grant (IDLE).
  - cycles t1–t4: FEED, four accepts.
  - cycle t5: WAIT, filter latches the average.
  - cycle t6: WAIT, `filt_done`=1, capture.
  - cycle t7: `out_valid`=1.
- Back-to-back throughput with `out_ready`=1 is one window per 8 cycles (IDLE → OUT → IDLE).
- Simultaneous `in_valid` on all channels during IDLE grants strictly in the order 0,1,2,…,`CHANNELS-1`,0,…
- Output handshake: transfer occurs on `out_valid`&`out_ready` at the rising edge. `out_valid` never drops without a transfer, except on reset.

## Test plan

- Channel 0 sends 10, 20, 30, 40 with no gaps and `out_ready`=1 → `out_data`=25, `out_chan`=0, `out_valid` high in cycle t7 only, `filt_fit` high exactly 4 cycles.
- All 4 channels valid continuously, with channel k sending constant 100·(k+1) → results 100,200,300,400,100 with `out_chan` 0,1,2,3,0. `in_ready` is one-hot throughout, and no sample from a non-granted channel is taken.
- Channel 2 sends 0xFFFF ×4 with 2-cycle `in_valid` gaps between samples → `out_data`=0xFFFF, `out_chan`=2, and `filt_fit` has 4 single-cycle pulses.
- Result held with `out_ready`=0 for 5 cycles → `out_data`/`out_chan` stable and `out_valid` high for 6 cycles. Channel 1 stays valid but is not granted until the accept.
- `filt_done` tied to 0 → `err`=1 after 8 WAIT cycles and the FSM returns to IDLE. The next grant goes to the following channel, and `err` stays 1 until `rst`=0.
- `rst` asserted after 2 accepts → all outputs return to reset values immediately. A fresh window of 4,4,8,8 on channel 0 → 6.

Source files
------------

// File: rtl/avg_channel_scheduler.sv
// Round-robin front end sharing one moving-average filter between channels.
// Streams one window per grant, then returns the tagged filter result.
module avg_channel_scheduler #(
    parameter int N        = 16,
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*N-1:0]        in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [N-1:0]                 filt_data,
    output logic                         filt_fit,
    input  logic                         filt_done,
    input  logic [N-1:0]                 filt_result,
    output logic [N-1:0]                 out_data,
    output logic [$clog2(CHANNELS)-1:0]  out_chan,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         err
);

    localparam int CW   = $clog2(CHANNELS);
    localparam int CNTW = $clog2(WINDOW + 1);
    localparam int WCW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_g;
    logic [CW-1:0]   r_last;
    logic [CNTW-1:0] r_cnt;
    logic [WCW-1:0]  r_wcnt;
    logic [N-1:0]    r_out_data;
    logic [CW-1:0]   r_out_chan;
    logic            r_err;

    logic [CW-1:0]   w_pick;
    logic            w_found;
    logic            w_sel_valid;
    logic [N-1:0]    w_sel_data;
    logic            w_last_acc;
    logic            w_tmo;

    assign w_sel_valid = in_valid[r_g];
    assign w_sel_data  = in_data[r_g*N +: N];
    assign w_last_acc  = w_sel_valid && (r_cnt == CNTW'(WINDOW - 1));
    assign w_tmo       = r_wcnt == WCW'(TIMEOUT - 1);

    assign busy     = r_state != S_IDLE;
    assign out_data = r_out_data;
    assign out_chan = r_out_chan;
    assign err      = r_err;

    // First valid channel searching upward from the one after the last grant
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            logic [CW-1:0] idx;
            idx = r_last + CW'(i);
            if (!w_found && in_valid[idx]) begin
                w_pick  = idx;
                w_found = 1'b1;
            end
        end
    end

    // Next state and per-state handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = '0;
        filt_fit  = 1'b0;
        filt_data = '0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_FEED;
            end
            S_FEED: begin
                in_ready[r_g] = 1'b1;
                filt_fit      = w_sel_valid;
                filt_data     = w_sel_data;
                if (w_last_acc) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (filt_done)  w_next = S_OUT;
                else if (w_tmo) w_next = S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Grant, counters, result capture and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g        <= '0;
            r_last     <= CW'(CHANNELS - 1);
            r_cnt      <= '0;
            r_wcnt     <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_g   <= w_pick;
                        r_cnt <= '0;
                    end
                end
                S_FEED: begin
                    if (w_sel_valid) r_cnt <= r_cnt + 1'b1;
                    if (w_last_acc)  r_wcnt <= '0;
                end
                S_WAIT: begin
                    if (filt_done) begin
                        r_out_data <= filt_result;
                        r_out_chan <= r_g;
                    end else if (w_tmo) begin
                        r_err  <= 1'b1;
                        r_last <= r_g;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) r_last <= r_g;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Directed bench for avg_channel_scheduler with a behavioural filter.
// Each scenario starts from reset and checks against hand-computed values.
module tb_avg_channel_scheduler;

    localparam int N  = 16;
    localparam int C  = 4;
    localparam int W  = 4;
    localparam int T  = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [C*N-1:0]  in_data;
    logic [C-1:0]    in_valid;
    logic [C-1:0]    in_ready;
    logic [N-1:0]    filt_data;
    logic            filt_fit;
    logic            filt_done;
    logic [N-1:0]    filt_result;
    logic [N-1:0]    out_data;
    logic [CW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    avg_channel_scheduler #(
        .N(N), .CHANNELS(C), .WINDOW(W), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_data(filt_data), .filt_fit(filt_fit),
        .filt_done(filt_done), .filt_result(filt_result),
        .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    // Filter model: sum W samples, latch floor(sum/4), pulse done next cycle
    logic [N+1:0] f_sum;
    logic [2:0]   f_cnt;
    logic         f_pend;
    logic         done_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_sum       <= '0;
            f_cnt       <= '0;
            f_pend      <= 1'b0;
            filt_done   <= 1'b0;
            filt_result <= '0;
        end else begin
            filt_done <= 1'b0;
            if (filt_fit) begin
                f_sum <= f_sum + {2'b00, filt_data};
                if (f_cnt == 3'(W - 1)) begin
                    f_cnt  <= '0;
                    f_pend <= 1'b1;
                end else begin
                    f_cnt <= f_cnt + 1'b1;
                end
            end
            if (f_pend) begin
                filt_result <= f_sum[N+1:2];
                filt_done   <= done_en;
                f_pend      <= 1'b0;
                f_sum       <= '0;
            end
        end
    end

    logic [N-1:0]  seq [C][8];
    int            pos [C];
    int            lim [C];
    int            gap [C];
    int            hold[C];
    int            cyc, fitcnt, fitrise, ovcnt, unstable, early1, viol;
    int            rdy_hold;
    bit            acc0;
    logic          prev_fit, prev_ovw;
    logic [N-1:0]  prev_d;
    logic [CW-1:0] prev_c;
    logic [N-1:0]  res_d[$];
    logic [CW-1:0] res_c[$];
    logic          log_ov  [64];
    logic          log_busy[64];
    logic          log_err [64];
    logic [C-1:0]  log_rdy [64];
    int            tests = 0;
    int            fails = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qd(int i);
        return (res_d.size() > i) ? 32'(res_d[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qc(int i);
        return (res_c.size() > i) ? 32'(res_c[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic fill(int k, logic [N-1:0] a, logic [N-1:0] b,
                        logic [N-1:0] c, logic [N-1:0] d);
        seq[k][0] = a; seq[k][1] = b; seq[k][2] = c; seq[k][3] = d;
        seq[k][4] = a; seq[k][5] = b; seq[k][6] = c; seq[k][7] = d;
    endtask

    task automatic drive();
        for (int k = 0; k < C; k++) begin
            in_valid[k] = (pos[k] < lim[k]) && (hold[k] == 0);
            in_data[k*N +: N] = (pos[k] < 8) ? seq[k][pos[k]] : '0;
        end
    endtask

    task automatic clear_bench();
        for (int k = 0; k < C; k++) begin
            pos[k] = 0; lim[k] = 0; gap[k] = 0; hold[k] = 0;
            for (int j = 0; j < 8; j++) seq[k][j] = '0;
        end
        for (int j = 0; j < 64; j++) begin
            log_ov[j] = 1'b0; log_busy[j] = 1'b0;
            log_err[j] = 1'b0; log_rdy[j] = '0;
        end
        cyc = 0; fitcnt = 0; fitrise = 0; ovcnt = 0;
        unstable = 0; early1 = 0; viol = 0; rdy_hold = 0;
        acc0 = 1'b0; prev_fit = 1'b0; prev_ovw = 1'b0;
        prev_d = '0; prev_c = '0;
        res_d.delete(); res_c.delete();
        out_ready = 1'b1;
        done_en = 1'b1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_bench();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock: sample before the edge, advance stimulus after it
    task automatic step();
        logic [C-1:0] acc;
        @(negedge clk);
        acc = in_ready & in_valid;
        if (cyc < 64) begin
            log_ov[cyc] = out_valid; log_busy[cyc] = busy;
            log_err[cyc] = err; log_rdy[cyc] = in_ready;
        end
        fitcnt += int'(filt_fit);
        if (filt_fit && !prev_fit) fitrise++;
        prev_fit = filt_fit;
        if ($countones(in_ready) > 1) viol++;
        if (in_ready[1] && !acc0) early1++;
        if (prev_ovw && (!out_valid || out_data !== prev_d || out_chan !== prev_c))
            unstable++;
        if (out_valid) begin
            ovcnt++;
            if (out_ready) begin
                res_d.push_back(out_data);
                res_c.push_back(out_chan);
                if (out_chan == 0) acc0 = 1'b1;
            end
        end
        prev_ovw = out_valid && !out_ready;
        prev_d = out_data;
        prev_c = out_chan;
        if (out_valid && !out_ready && rdy_hold > 0) rdy_hold--;
        @(posedge clk);
        #1;
        for (int k = 0; k < C; k++) begin
            if (hold[k] > 0) hold[k]--;
            if (acc[k]) begin
                pos[k]++;
                hold[k] = gap[k];
            end
        end
        out_ready = (rdy_hold == 0);
        cyc++;
        drive();
    endtask

    initial begin
        in_data = '0; in_valid = '0; out_ready = 1'b1; done_en = 1'b1;

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_fit", filt_fit, 0);
        check("rst_filt_data", filt_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_err", err, 0);

        // Single window on channel 0, minimum latency
        do_reset();
        fill(0, 10, 20, 30, 40);
        lim[0] = 4;
        drive();
        repeat (12) step();
        check("t1_count", res_d.size(), 1);
        check("t1_data", qd(0), 25);
        check("t1_chan", qc(0), 0);
        check("t1_busy_t0", log_busy[0], 0);
        check("t1_ready_t1", log_rdy[1], 4'b0001);
        check("t1_ov_t6", log_ov[6], 0);
        check("t1_ov_t7", log_ov[7], 1);
        check("t1_ov_cycles", ovcnt, 1);
        check("t1_fit_cycles", fitcnt, 4);

        // All channels requesting, strict rotation
        do_reset();
        for (int k = 0; k < C; k++) begin
            fill(k, N'(100*(k+1)), N'(100*(k+1)), N'(100*(k+1)), N'(100*(k+1)));
            lim[k] = 4;
        end
        lim[0] = 8;
        drive();
        repeat (48) step();
        check("t2_count", res_d.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_data%0d", i), qd(i), 100 * ((i % 4) + 1));
            check($sformatf("t2_chan%0d", i), qc(i), i % 4);
        end
        check("t2_onehot", viol, 0);
        check("t2_fit_cycles", fitcnt, 20);
        check("t2_ov_t7", log_ov[7], 1);
        check("t2_ov_t15", log_ov[15], 1);

        // Gapped samples on channel 2
        do_reset();
        fill(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        lim[2] = 4;
        gap[2] = 2;
        drive();
        repeat (20) step();
        check("t3_count", res_d.size(), 1);
        check("t3_data", qd(0), 16'hFFFF);
        check("t3_chan", qc(0), 2);
        check("t3_fit_pulses", fitrise, 4);
        check("t3_fit_cycles", fitcnt, 4);
        check("t3_ov_t13", log_ov[13], 1);

        // Back-pressure on the output while channel 1 waits
        do_reset();
        fill(0, 1, 2, 3, 6);
        fill(1, 7, 7, 7, 7);
        lim[0] = 4;
        lim[1] = 4;
        rdy_hold = 5;
        out_ready = 1'b0;
        drive();
        repeat (26) step();
        check("t4_count", res_d.size(), 2);
        check("t4_data0", qd(0), 3);
        check("t4_chan0", qc(0), 0);
        check("t4_data1", qd(1), 7);
        check("t4_chan1", qc(1), 1);
        check("t4_ov_cycles", ovcnt, 7);
        check("t4_stable", unstable, 0);
        check("t4_no_early_grant", early1, 0);

        // Filter never answers: timeout, sticky error, next channel
        do_reset();
        done_en = 1'b0;
        fill(0, 5, 5, 5, 5);
        fill(1, 5, 5, 5, 5);
        lim[0] = 4;
        lim[1] = 4;
        drive();
        repeat (30) step();
        check("t5_err_t12", log_err[12], 0);
        check("t5_err_t13", log_err[13], 1);
        check("t5_busy_t12", log_busy[12], 1);
        check("t5_busy_t13", log_busy[13], 0);
        check("t5_next_grant", log_rdy[14], 4'b0010);
        check("t5_busy_t26", log_busy[26], 0);
        check("t5_no_output", ovcnt, 0);
        check("t5_err_sticky", err, 1);
        do_reset();
        check("t5_err_cleared", err, 0);

        // Reset in the middle of a window, then a clean window
        do_reset();
        fill(0, 9, 9, 9, 9);
        lim[0] = 8;
        drive();
        for (int i = 0; i < 20 && pos[0] < 2; i++) step();
        check("t6_two_accepts", pos[0], 2);
        check("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_fit", filt_fit, 0);
        check("t6_filt_data", filt_data, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_err", err, 0);
        clear_bench();
        #2 rst = 1'b1;
        fill(0, 4, 4, 8, 8);
        lim[0] = 4;
        drive();
        repeat (12) step();
        check("t6_count", res_d.size(), 1);
        check("t6_data", qd(0), 6);
        check("t6_chan", qc(0), 0);
        check("t6_ov_t7", log_ov[7], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
